clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock/tick generator that derives several slow, independently programmable enable-clocks from the single board clock. Each channel has its own period, high time and enable, plus a one-cycle tick at every period start. Ratio changes are double-buffered and take effect only at a period boundary, so outputs never glitch. A global sync strobe phase-aligns all running channels. It feeds display multiplexing, debouncers and LED blinkers.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 26, counter / ratio width in bits
- DEFAULT_PERIOD, 50_000_000, period loaded into every channel at reset (≥2, < 2^WIDTH)
- DEFAULT_HIGH, 25_000_000, high time loaded into every channel at reset

- clk_in  input  1  sole clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  CHANNELS  per-channel run enable
- load  input  CHANNELS  per-channel strobe: capture new period/high into shadow
- div_period  input  CHANNELS*WIDTH  period per channel, channel i at [i*WIDTH +: WIDTH]
- div_high  input  CHANNELS*WIDTH  high time per channel, same packing
- sync  input  1  restart all enabled channels at count 0
- clk_out  output  CHANNELS  divided clock, registered
- tick  output  CHANNELS  one-cycle pulse at each period start, registered
- pending  output  CHANNELS  shadow value waiting to be applied

## Operation
- Per channel state: cnt[WIDTH], active P/H, shadow P/H, pending flag.
- Effective period P' = max(P, 2); out-of-range values never stall the counter.
- Enabled edge: cnt_next = (cnt ≥ P'−1) ? 0 : cnt+1; cnt ← cnt_next; clk_out ← (cnt_next < H); tick ← (cnt_next == 0).
- H = 0 → clk_out constantly 0; H ≥ P' → constantly 1; tick still fires every P' cycles.
- enable low: cnt and clk_out hold, tick ← 0, sync ignored for that channel.
- load[i] high: shadow ← div_period/div_high slice; pending ← 1. A later load before application overwrites the shadow.
- Application (channel enabled): at the edge where cnt_next == 0 and pending was already 1 before that edge, active ← shadow, pending ← 0. Output for that edge uses the new H.
- Application (channel disabled): on load, active ← input values, cnt ← 0, pending stays 0.
- sync: every enabled channel takes cnt ← 0, clk_out ← (0 < H), tick ← 1, and applies a pending shadow as at a wrap. sync has priority over the natural count.
- load and wrap/sync on the same edge: the value is captured into shadow only and applied at the next wrap or sync.

## Timing
- Reset (asynchronous, rst_n low): cnt = 0, active P = DEFAULT_PERIOD, H = DEFAULT_HIGH, shadows = defaults, pending = 0, clk_out = 0, tick = 0.
- First enabled edge after reset: cnt = 1, so the first full period starts one edge late. The first tick occurs at edge P'.
- Steady state: tick period P' edges; clk_out high for H edges starting at the tick edge, low for P'−H.
- Latency enable→first count: 1 edge. load→pending visible: 1 edge. Pending→applied: at the next wrap or sync edge.
- Reset asserted mid-period: outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, P=4, H=2, enable=1: clk_out over edges 1..8 = 1,0,0,1,1,0,0,1; tick high only at edges 4 and 8.
- Running P=4, H=2: load P=6, H=3 at edge 2. pending=1 from edge 3; wrap at edge 4 applies it, pending=0. Then 3 high, 3 low, with ticks at edges 4 and 10.
- P=1 and P=0: period behaves as 2 with a tick every 2 edges. H=0 gives clk_out stuck 0; H=9 with P=4 gives clk_out stuck 1.
- Two channels, P=5 and P=3, free-running: pulse sync. Both tick on the same edge and clk_out rises together. A disabled third channel is unaffected.
- enable dropped mid-period for 7 edges: cnt and clk_out frozen, tick 0. Counting resumes from the held cnt.
- Assert rst_n low between clock edges: clk_out and tick go to 0 immediately. After release with DEFAULT_PERIOD=10 (bench override), the first tick occurs at edge 10.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable enable-clock / tick generator.
// Ratio updates are double-buffered and only take effect at a period boundary or sync.
module clk_div_multi #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000,
  parameter int unsigned DEFAULT_HIGH   = 25_000_000
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_period,
  input  logic [CHANNELS*WIDTH-1:0] div_high,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HIGH);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] sper_q, sper_d;
    logic [WIDTH-1:0] shi_q, shi_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] in_per, in_hi, per_eff, cnt_next, hi_use;
    logic             wrap;

    assign in_per  = div_period[g*WIDTH +: WIDTH];
    assign in_hi   = div_high[g*WIDTH +: WIDTH];
    // Periods below 2 are clamped so the counter always wraps.
    assign per_eff = (per_q < TWO) ? TWO : per_q;

    always_comb begin
      cnt_d    = cnt_q;
      per_d    = per_q;
      hi_d     = hi_q;
      sper_d   = sper_q;
      shi_d    = shi_q;
      pend_d   = pend_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      hi_use   = hi_q;
      cnt_next = (sync || (cnt_q >= per_eff - ONE)) ? '0 : cnt_q + ONE;
      wrap     = (cnt_next == '0);

      if (enable[g]) begin
        if (wrap && pend_q) begin
          per_d  = sper_q;
          hi_d   = shi_q;
          hi_use = shi_q;
          pend_d = 1'b0;
        end
        // A load coinciding with a wrap only refills the shadow; it waits for the next boundary.
        if (load[g]) begin
          sper_d = in_per;
          shi_d  = in_hi;
          pend_d = 1'b1;
        end
        cnt_d  = cnt_next;
        clk_d  = (cnt_next < hi_use);
        tick_d = wrap;
      end else if (load[g]) begin
        per_d  = in_per;
        hi_d   = in_hi;
        sper_d = in_per;
        shi_d  = in_hi;
        pend_d = 1'b0;
        cnt_d  = '0;
      end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        per_q  <= DEF_P;
        hi_q   <= DEF_H;
        sper_q <= DEF_P;
        shi_q  <= DEF_H;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        hi_q   <= hi_d;
        sper_q <= sper_d;
        shi_q  <= shi_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a per-edge vector table on channel 0 plus
// hand-written sequences for sync, enable freeze and asynchronous reset.
module tb_clk_div_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   enable, load;
  logic [CH*W-1:0] div_period, div_high;
  logic            sync;
  logic [CH-1:0]   clk_out, tick, pending;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_multi #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(10), .DEFAULT_HIGH(5)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .load(load),
    .div_period(div_period), .div_high(div_high), .sync(sync),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] per;
    logic [W-1:0] hi;
    logic         clk_e;
    logic         tick_e;
    logic         pend_e;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic en, input logic ld, input logic [W-1:0] per,
                     input logic [W-1:0] hi, input logic c, input logic t, input logic p);
    vec_t v;
    v.en = en; v.ld = ld; v.per = per; v.hi = hi;
    v.clk_e = c; v.tick_e = t; v.pend_e = p;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] p, input logic [W-1:0] h);
    div_period[c*W +: W] = p;
    div_high[c*W +: W]   = h;
  endtask

  initial begin
    logic [1:0] t_exp [4];

    rst_n = 1'b0; enable = '0; load = '0; sync = 1'b0;
    div_period = '0; div_high = '0;

    // Channel 0 table: each row is one clock edge, expectations hand-derived.
    // Prefix: P=4 H=2 from count 0, 1,0,0,1,1,0,0,1 with ticks at 4 and 8.
    add(1,0,0,0, 1,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 1,1,0);
    add(1,0,0,0, 1,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 1,1,0);
    // Load P=6 H=3 on the second edge of a period; applied at the wrap.
    add(1,0,0,0, 1,0,0); add(1,1,6,3, 0,0,1); add(1,0,0,0, 0,0,1); add(1,0,0,0, 1,1,0);
    add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0); add(1,0,0,0, 1,1,0);
    // Disabled load P=1 H=0: immediate, clk_out held, then period 2 stuck low.
    add(0,1,1,0, 1,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,1,0); add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,1,0);
    // P=0 H=9: period 2, stuck high.
    add(0,1,0,9, 0,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,1,0); add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,1,0);
    // P=4 H=9: stuck high, tick every 4.
    add(0,1,4,9, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,1,0);

    #3;
    for (int c = 0; c < CH; c++) begin
      chk1($sformatf("rst_clk%0d", c), clk_out[c], 1'b0);
      chk1($sformatf("rst_tick%0d", c), tick[c], 1'b0);
      chk1($sformatf("rst_pend%0d", c), pending[c], 1'b0);
    end
    step(); step();
    rst_n = 1'b1;

    load[0] = 1'b1; set_ch(0, 8'd4, 8'd2);
    step();
    load[0] = 1'b0;
    chk1("setup_pend0", pending[0], 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      enable[0] = vq[i].en;
      load[0]   = vq[i].ld;
      set_ch(0, vq[i].per, vq[i].hi);
      step();
      load[0] = 1'b0;
      chk1($sformatf("vec%0d_clk", i+1), clk_out[0], vq[i].clk_e);
      chk1($sformatf("vec%0d_tick", i+1), tick[0], vq[i].tick_e);
      chk1($sformatf("vec%0d_pend", i+1), pending[0], vq[i].pend_e);
    end

    // Sync: ch1 P=5 H=2, ch2 P=3 H=1, ch3 disabled P=7 H=3.
    enable = '0;
    load = 4'b1110;
    set_ch(1, 8'd5, 8'd2); set_ch(2, 8'd3, 8'd1); set_ch(3, 8'd7, 8'd3);
    step();
    load = '0;
    chk1("sy_setup_pend2", pending[2], 1'b0);
    enable = 4'b0110;
    step();
    chk1("sy_e1_clk1", clk_out[1], 1'b1);
    chk1("sy_e1_clk2", clk_out[2], 1'b0);
    step();
    load[2] = 1'b1; set_ch(2, 8'd4, 8'd2);
    step();
    load[2] = 1'b0;
    chk1("sy_e3_tick2", tick[2], 1'b1);
    chk1("sy_e3_clk2_oldh", clk_out[2], 1'b1);
    chk1("sy_e3_pend2", pending[2], 1'b1);
    step();
    chk1("sy_e4_clk1", clk_out[1], 1'b0);
    chk1("sy_e4_clk2", clk_out[2], 1'b0);
    chk1("sy_e4_pend2", pending[2], 1'b1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk1("sy_tick1", tick[1], 1'b1);
    chk1("sy_tick2", tick[2], 1'b1);
    chk1("sy_clk1", clk_out[1], 1'b1);
    chk1("sy_clk2", clk_out[2], 1'b1);
    chk1("sy_pend2", pending[2], 1'b0);
    chk1("sy_tick3_dis", tick[3], 1'b0);
    chk1("sy_clk3_dis", clk_out[3], 1'b0);
    step();
    chk1("sy_p1_clk1", clk_out[1], 1'b1);
    chk1("sy_p1_clk2_newh", clk_out[2], 1'b1);
    chk1("sy_p1_tick1", tick[1], 1'b0);
    chk1("sy_p1_tick2", tick[2], 1'b0);
    t_exp[0] = 2'b00; t_exp[1] = 2'b00; t_exp[2] = 2'b10; t_exp[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("sy_p%0d_tick1", i+2), tick[1], t_exp[i][0]);
      chk1($sformatf("sy_p%0d_tick2", i+2), tick[2], t_exp[i][1]);
    end

    // Enable freeze on ch1 (cnt 1, clk high), sync pulsed while frozen.
    step();
    chk1("fr_pre_clk1", clk_out[1], 1'b1);
    enable[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sync = (i == 2);
      step();
      chk1($sformatf("fr%0d_clk1", i), clk_out[1], 1'b1);
      chk1($sformatf("fr%0d_tick1", i), tick[1], 1'b0);
    end
    sync = 1'b0;
    enable[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("res%0d_clk1", i), clk_out[1], i == 3);
      chk1($sformatf("res%0d_tick1", i), tick[1], i == 3);
    end

    // Asynchronous reset between edges, then defaults P=10 H=5 on ch0.
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < CH; c++) begin
      chk1($sformatf("arst_clk%0d", c), clk_out[c], 1'b0);
      chk1($sformatf("arst_tick%0d", c), tick[c], 1'b0);
      chk1($sformatf("arst_pend%0d", c), pending[c], 1'b0);
    end
    enable = 4'b0001;
    step(); step();
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk1($sformatf("def_e%0d_clk0", e), clk_out[0], (e <= 4) || (e == 10));
      chk1($sformatf("def_e%0d_tick0", e), tick[0], e == 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
